// File: rtl/miner_pkg.sv
// Shared miner datapath types and default widths for the dispatcher and hash-core wrappers.
package miner_pkg;

  localparam int unsigned NONCE_W_DEF = 32;
  localparam int unsigned CNT_W_DEF   = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } disp_state_t;

endpackage

// File: rtl/nonce_range_dispatcher.sv
// Hands out consecutive nonces of a job (start, count) over a valid/ready stream,
// tracking remaining and issued counts and pulsing done on exhaustion or abort.
module nonce_range_dispatcher
  import miner_pkg::*;
#(
  parameter int unsigned NONCE_W = NONCE_W_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [NONCE_W-1:0] cfg_start,
  input  logic [CNT_W-1:0]   cfg_count,
  input  logic               abort,
  output logic               nonce_valid,
  input  logic               nonce_ready,
  output logic [NONCE_W-1:0] nonce_data,
  output logic               nonce_last,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic [CNT_W-1:0]   issued_cnt
);

  disp_state_t        state_q;
  logic [NONCE_W-1:0] cur_q;
  logic [CNT_W-1:0]   rem_q;
  logic [CNT_W-1:0]   issued_q;
  logic               cfg_ready_q;
  logic               valid_q;
  logic               last_q;
  logic               busy_q;
  logic               done_q;
  logic               aborted_q;
  logic               xfer;

  assign xfer = valid_q & nonce_ready;

  // All outputs come straight from registers; done is a single-cycle pulse into FIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_q       <= '0;
      rem_q       <= '0;
      issued_q    <= '0;
      cfg_ready_q <= 1'b1;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cfg_valid) begin
            cur_q       <= cfg_start;
            rem_q       <= cfg_count;
            issued_q    <= '0;
            aborted_q   <= 1'b0;
            cfg_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (cfg_count != '0) begin
              state_q <= RUN;
              valid_q <= 1'b1;
              last_q  <= (cfg_count == CNT_W'(1));
            end else begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (xfer) begin
            cur_q  <= cur_q + NONCE_W'(1);
            rem_q  <= rem_q - CNT_W'(1);
            last_q <= (rem_q == CNT_W'(2));
            if (issued_q != {CNT_W{1'b1}}) begin
              issued_q <= issued_q + CNT_W'(1);
            end
          end
          // A transfer coinciding with abort is still counted above.
          if ((xfer && rem_q == CNT_W'(1)) || abort) begin
            state_q   <= FIN;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            done_q    <= 1'b1;
            aborted_q <= abort;
          end
        end
        FIN: begin
          state_q     <= IDLE;
          busy_q      <= 1'b0;
          cfg_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= IDLE;
          valid_q     <= 1'b0;
          last_q      <= 1'b0;
          busy_q      <= 1'b0;
          cfg_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign cfg_ready   = cfg_ready_q;
  assign nonce_valid = valid_q;
  assign nonce_data  = cur_q;
  assign nonce_last  = last_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign aborted     = aborted_q;
  assign issued_cnt  = issued_q;

endmodule

// File: tb/tb_nonce_range_dispatcher.sv
// Directed self-checking bench for nonce_range_dispatcher: one task per scenario.
module tb_nonce_range_dispatcher;

  logic        clk;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_start;
  logic [31:0] cfg_count;
  logic        abort;
  logic        nonce_valid;
  logic        nonce_ready;
  logic [31:0] nonce_data;
  logic        nonce_last;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [31:0] issued_cnt;

  int cmp_cnt = 0;
  int err_cnt = 0;

  nonce_range_dispatcher #(.NONCE_W(32), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_start(cfg_start), .cfg_count(cfg_count),
    .abort(abort),
    .nonce_valid(nonce_valid), .nonce_ready(nonce_ready),
    .nonce_data(nonce_data), .nonce_last(nonce_last),
    .busy(busy), .done(done), .aborted(aborted), .issued_cnt(issued_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required<200000", $time);
    $fatal(1, "watchdog expired");
  end

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cfg(input logic [31:0] start, input logic [31:0] count);
    cfg_start = start;
    cfg_count = count;
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_valid = 1'b0; abort = 1'b0; nonce_ready = 1'b0;
    cfg_start = '0; cfg_count = '0;
    step(); step();
    rst = 1'b0;
    cmp_cnt++; if (cfg_ready !== 1'b1) begin err_cnt++; $display("FAIL reset_cfg_ready got=%b exp=1", cfg_ready); end
    cmp_cnt++; if (nonce_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_valid got=%b exp=0", nonce_valid); end
    cmp_cnt++; if ({nonce_last, busy, done, aborted} !== 4'b0) begin err_cnt++; $display("FAIL reset_flags got=%b exp=0000", {nonce_last, busy, done, aborted}); end
    cmp_cnt++; if (nonce_data !== 32'h0) begin err_cnt++; $display("FAIL reset_data got=%h exp=0", nonce_data); end
    cmp_cnt++; if (issued_cnt !== 32'h0) begin err_cnt++; $display("FAIL reset_issued got=%0d exp=0", issued_cnt); end
  endtask

  task automatic test_abort_idle();
    abort = 1'b1;
    step();
    abort = 1'b0;
    cmp_cnt++; if ({busy, done, aborted, cfg_ready} !== 4'b0001) begin err_cnt++; $display("FAIL abort_idle got=%b exp=0001", {busy, done, aborted, cfg_ready}); end
  endtask

  // Full-rate job with ready held high; also used for the wrap-through-zero case.
  task automatic run_stream(input string name, input logic [31:0] start, input int count);
    logic [31:0] exp_data;
    nonce_ready = 1'b1;
    send_cfg(start, 32'(count));
    cmp_cnt++; if (cfg_ready !== 1'b0) begin err_cnt++; $display("FAIL %s_cfg_ready_run got=%b exp=0", name, cfg_ready); end
    for (int i = 0; i < count; i++) begin
      exp_data = start + 32'(i);
      cmp_cnt++; if (nonce_valid !== 1'b1 || nonce_data !== exp_data || nonce_last !== (i == count - 1) || done !== 1'b0) begin
        err_cnt++; $display("FAIL %s_beat%0d got v=%b d=%h l=%b dn=%b exp v=1 d=%h l=%b dn=0", name, i, nonce_valid, nonce_data, nonce_last, done, exp_data, (i == count - 1));
      end
      step();
    end
    cmp_cnt++; if ({done, busy, nonce_valid, aborted} !== 4'b1100) begin err_cnt++; $display("FAIL %s_done got dn/bz/v/ab=%b exp=1100", name, {done, busy, nonce_valid, aborted}); end
    cmp_cnt++; if (issued_cnt !== 32'(count)) begin err_cnt++; $display("FAIL %s_issued got=%0d exp=%0d", name, issued_cnt, count); end
    step();
    cmp_cnt++; if ({done, busy, cfg_ready} !== 3'b001) begin err_cnt++; $display("FAIL %s_idle got dn/bz/rdy=%b exp=001", name, {done, busy, cfg_ready}); end
  endtask

  task automatic test_back_to_back();
    run_stream("b2b", 32'h10, 4);
  endtask

  task automatic test_wrap();
    run_stream("wrap", 32'hFFFF_FFFE, 3);
  endtask

  task automatic test_zero_count();
    nonce_ready = 1'b1;
    send_cfg(32'h1234, 32'h0);
    cmp_cnt++; if ({nonce_valid, done, busy, cfg_ready} !== 4'b0110) begin err_cnt++; $display("FAIL zero_fin got v/dn/bz/rdy=%b exp=0110", {nonce_valid, done, busy, cfg_ready}); end
    cmp_cnt++; if (issued_cnt !== 32'h0) begin err_cnt++; $display("FAIL zero_issued got=%0d exp=0", issued_cnt); end
    step();
    cmp_cnt++; if ({nonce_valid, done, busy, cfg_ready} !== 4'b0001) begin err_cnt++; $display("FAIL zero_idle got v/dn/bz/rdy=%b exp=0001", {nonce_valid, done, busy, cfg_ready}); end
  endtask

  // Ready pattern 1,0,0 repeating; data/last must hold through stalls.
  task automatic test_stall();
    int k;
    int cyc;
    logic rdy;
    k = 0;
    cyc = 0;
    nonce_ready = 1'b0;
    send_cfg(32'h200, 32'd5);
    while (k < 5 && cyc < 40) begin
      rdy = (cyc % 3) == 0;
      nonce_ready = rdy;
      cmp_cnt++; if (nonce_valid !== 1'b1 || nonce_data !== 32'h200 + 32'(k) || nonce_last !== (k == 4)) begin
        err_cnt++; $display("FAIL stall_cyc%0d got v=%b d=%h l=%b exp v=1 d=%h l=%b", cyc, nonce_valid, nonce_data, nonce_last, 32'h200 + 32'(k), (k == 4));
      end
      step();
      if (rdy) k++;
      cyc++;
    end
    nonce_ready = 1'b0;
    cmp_cnt++; if (k !== 5) begin err_cnt++; $display("FAIL stall_budget got transfers=%0d exp=5", k); end
    cmp_cnt++; if ({done, nonce_valid} !== 2'b10 || issued_cnt !== 32'd5) begin err_cnt++; $display("FAIL stall_done got dn/v=%b issued=%0d exp dn/v=10 issued=5", {done, nonce_valid}, issued_cnt); end
    step();
  endtask

  task automatic test_abort();
    nonce_ready = 1'b1;
    send_cfg(32'h1000, 32'd100);
    for (int i = 0; i < 7; i++) step();
    cmp_cnt++; if (nonce_data !== 32'h1007 || issued_cnt !== 32'd7) begin err_cnt++; $display("FAIL abort_pre got d=%h issued=%0d exp d=00001007 issued=7", nonce_data, issued_cnt); end
    abort = 1'b1;
    step();
    abort = 1'b0;
    cmp_cnt++; if ({done, aborted, nonce_valid} !== 3'b110) begin err_cnt++; $display("FAIL abort_fin got dn/ab/v=%b exp=110", {done, aborted, nonce_valid}); end
    cmp_cnt++; if (issued_cnt !== 32'd8) begin err_cnt++; $display("FAIL abort_issued got=%0d exp=8", issued_cnt); end
    step();
    cmp_cnt++; if ({done, aborted, cfg_ready} !== 3'b011) begin err_cnt++; $display("FAIL abort_hold got dn/ab/rdy=%b exp=011", {done, aborted, cfg_ready}); end
    nonce_ready = 1'b0;
    send_cfg(32'h50, 32'd1);
    cmp_cnt++; if ({aborted, nonce_valid, nonce_last} !== 3'b011 || nonce_data !== 32'h50) begin err_cnt++; $display("FAIL abort_clear got ab/v/l=%b d=%h exp ab/v/l=011 d=00000050", {aborted, nonce_valid, nonce_last}, nonce_data); end
    nonce_ready = 1'b1;
    step();
    cmp_cnt++; if ({done, aborted} !== 2'b10 || issued_cnt !== 32'd1) begin err_cnt++; $display("FAIL abort_next got dn/ab=%b issued=%0d exp dn/ab=10 issued=1", {done, aborted}, issued_cnt); end
    step();
  endtask

  task automatic test_abort_on_last();
    nonce_ready = 1'b1;
    send_cfg(32'h77, 32'd2);
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    cmp_cnt++; if ({done, aborted} !== 2'b11 || issued_cnt !== 32'd2) begin err_cnt++; $display("FAIL abort_last got dn/ab=%b issued=%0d exp dn/ab=11 issued=2", {done, aborted}, issued_cnt); end
    step();
  endtask

  task automatic test_rst_mid();
    nonce_ready = 1'b1;
    send_cfg(32'hABC0, 32'd10);
    for (int i = 0; i < 3; i++) step();
    cmp_cnt++; if (issued_cnt !== 32'd3 || nonce_data !== 32'hABC3) begin err_cnt++; $display("FAIL rst_mid_pre got issued=%0d d=%h exp issued=3 d=0000abc3", issued_cnt, nonce_data); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    cmp_cnt++; if ({cfg_ready, nonce_valid, nonce_last, busy, done, aborted} !== 6'b100000) begin err_cnt++; $display("FAIL rst_mid_flags got=%b exp=100000", {cfg_ready, nonce_valid, nonce_last, busy, done, aborted}); end
    cmp_cnt++; if (nonce_data !== 32'h0 || issued_cnt !== 32'h0) begin err_cnt++; $display("FAIL rst_mid_regs got d=%h issued=%0d exp d=0 issued=0", nonce_data, issued_cnt); end
    step();
    cmp_cnt++; if (done !== 1'b0) begin err_cnt++; $display("FAIL rst_mid_nodone got=%b exp=0", done); end
  endtask

  initial begin
    test_reset();
    test_abort_idle();
    test_back_to_back();
    test_wrap();
    test_zero_count();
    test_stall();
    test_abort();
    test_abort_on_last();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
